fpu_issue_queue: RTL and testbench

FPU_ISSUE_QUEUE -- requirements
Module: fpu_issue_queue

---
 rtl/fpnew_pkg.sv | 58 +++++
 rtl/fpu_issue_decode.sv | 32 +++
 rtl/fpu_issue_queue.sv | 139 +++++++++++++
 tb/tb_fpu_issue_queue.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPU types: operation/format enums, opgroup lookup and the issue-queue entry.
package fpnew_pkg;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY,
    F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [1:0] {
    ADDMUL, DIVSQRT, NONCOMP, CONV
  } opgroup_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [2:0] {
    FP32, FP64, FP16, FP8, FP16ALT
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8, INT16, INT32, INT64
  } int_format_e;

  // Queue entries reserve a full 32-bit tag; narrower tags are zero-extended on enqueue.
  localparam int unsigned ISSUE_TAG_MAX_WIDTH = 32;

  typedef struct packed {
    logic [2:0][31:0]                 operands;
    operation_e                       op;
    logic                             op_mod;
    fp_format_e                       src_fmt;
    fp_format_e                       dst_fmt;
    int_format_e                      int_fmt;
    roundmode_e                       rnd_mode;
    opgroup_e                         opgroup;
    logic                             illegal;
    logic [ISSUE_TAG_MAX_WIDTH-1:0]   tag;
  } fpu_issue_entry_t;

  // Encodings beyond CPKCD are not operations; they land in NONCOMP.
  function automatic opgroup_e get_opgroup(input operation_e op);
    case (op)
      FMADD, FNMSUB, ADD, MUL:        return ADDMUL;
      DIV, SQRT:                      return DIVSQRT;
      SGNJ, MINMAX, CMP, CLASSIFY:    return NONCOMP;
      F2F, F2I, I2F, CPKAB, CPKCD:    return CONV;
      default:                        return NONCOMP;
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_decode.sv
// Enqueue-time decode: resolves the dynamic rounding mode, flags illegal requests
// and classifies the operation into its opgroup.
module fpu_issue_decode
  import fpnew_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [2:0] src_fmt_i,
  input  logic [2:0] dst_fmt_i,
  input  logic [2:0] rnd_mode_i,
  input  logic [2:0] frm_i,
  output logic [2:0] rnd_mode_o,
  output logic [1:0] opgroup_o,
  output logic       illegal_o
);

  logic [2:0] resolvedMode;
  logic       badMode;
  logic       badOp;
  logic       badFmt;

  // Resolve DYN against the CSR, then reject reserved modes, encodings and formats.
  always_comb begin
    resolvedMode = (rnd_mode_i == DYN) ? frm_i : rnd_mode_i;
    badMode      = (resolvedMode >= 3'(ROD));
    badOp        = (op_i > 4'(CPKCD));
    badFmt       = (src_fmt_i > 3'(FP16ALT)) || (dst_fmt_i > 3'(FP16ALT));
    illegal_o    = badMode || badOp || badFmt;
    rnd_mode_o   = illegal_o ? 3'(RNE) : resolvedMode;
    opgroup_o    = 2'(get_opgroup(operation_e'(op_i)));
  end

endmodule

// File: rtl/fpu_issue_queue.sv
// FIFO of decoded FPU requests between the issue stage and the FPU.
// Registered output only (no empty bypass); flush outranks push and pop.
// TagWidth is legal up to ISSUE_TAG_MAX_WIDTH.
module fpu_issue_queue
  import fpnew_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter int unsigned TagWidth = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic [2:0]                  frm_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [2:0][31:0]            operands_i,
  input  logic [3:0]                  op_i,
  input  logic                        op_mod_i,
  input  logic [2:0]                  src_fmt_i,
  input  logic [2:0]                  dst_fmt_i,
  input  logic [1:0]                  int_fmt_i,
  input  logic [2:0]                  rnd_mode_i,
  input  logic [TagWidth-1:0]         tag_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [2:0][31:0]            out_operands_o,
  output logic [3:0]                  out_op_o,
  output logic                        out_op_mod_o,
  output logic [2:0]                  out_src_fmt_o,
  output logic [2:0]                  out_dst_fmt_o,
  output logic [1:0]                  out_int_fmt_o,
  output logic [2:0]                  out_rnd_mode_o,
  output logic [TagWidth-1:0]         out_tag_o,
  output logic [1:0]                  out_opgroup_o,
  output logic                        out_illegal_o,
  output logic [$clog2(Depth+1)-1:0]  count_o,
  output logic                        busy_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [PtrWidth-1:0] wrPtr_q, wrPtr_d;
  logic [PtrWidth-1:0] rdPtr_q, rdPtr_d;
  logic [CntWidth-1:0] count_q, count_d;
  fpu_issue_entry_t    mem_q [Depth];
  fpu_issue_entry_t    newEntry;
  fpu_issue_entry_t    head;
  logic                pushEn;
  logic                popEn;
  logic [2:0]          decRndMode;
  logic [1:0]          decOpgroup;
  logic                decIllegal;

  function automatic logic [PtrWidth-1:0] incPtr(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  assign in_ready_o  = (count_q < CntWidth'(Depth));
  assign out_valid_o = (count_q != '0);
  assign busy_o      = out_valid_o;
  assign count_o     = count_q;
  assign pushEn      = in_valid_i && in_ready_o;
  assign popEn       = out_valid_o && out_ready_i;

  fpu_issue_decode u_decode (
    .op_i       (op_i),
    .src_fmt_i  (src_fmt_i),
    .dst_fmt_i  (dst_fmt_i),
    .rnd_mode_i (rnd_mode_i),
    .frm_i      (frm_i),
    .rnd_mode_o (decRndMode),
    .opgroup_o  (decOpgroup),
    .illegal_o  (decIllegal)
  );

  // Assemble the entry written on a push, combining raw fields with the decode.
  always_comb begin
    newEntry          = '0;
    newEntry.operands = operands_i;
    newEntry.op       = operation_e'(op_i);
    newEntry.op_mod   = op_mod_i;
    newEntry.src_fmt  = fp_format_e'(src_fmt_i);
    newEntry.dst_fmt  = fp_format_e'(dst_fmt_i);
    newEntry.int_fmt  = int_format_e'(int_fmt_i);
    newEntry.rnd_mode = roundmode_e'(decRndMode);
    newEntry.opgroup  = opgroup_e'(decOpgroup);
    newEntry.illegal  = decIllegal;
    newEntry.tag      = ISSUE_TAG_MAX_WIDTH'(tag_i);
  end

  // Pointer and occupancy update; a flush wipes both and swallows push/pop.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushEn) wrPtr_d = incPtr(wrPtr_q);
      if (popEn)  rdPtr_d = incPtr(rdPtr_q);
      if (pushEn && !popEn)      count_d = count_q + CntWidth'(1);
      else if (popEn && !pushEn) count_d = count_q - CntWidth'(1);
    end
  end

  // Occupancy state; reset empties the queue immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: slots are only visible while counted valid.
  always_ff @(posedge clk_i) begin
    if (pushEn && !flush_i) mem_q[wrPtr_q] <= newEntry;
  end

  assign head           = mem_q[rdPtr_q];
  assign out_operands_o = head.operands;
  assign out_op_o       = head.op;
  assign out_op_mod_o   = head.op_mod;
  assign out_src_fmt_o  = head.src_fmt;
  assign out_dst_fmt_o  = head.dst_fmt;
  assign out_int_fmt_o  = head.int_fmt;
  assign out_rnd_mode_o = head.rnd_mode;
  assign out_opgroup_o  = head.opgroup;
  assign out_illegal_o  = head.illegal;
  assign out_tag_o      = TagWidth'(head.tag);

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Self-checking bench for fpu_issue_queue: directed corner sequences, a decode
// vector table and a randomized run against a queue-based reference model.
module tb_fpu_issue_queue;

  localparam int DEPTH = 2;
  localparam int TAGW  = 5;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [2:0]       frm;
  logic             inValid;
  logic             inReady;
  logic [2:0][31:0] operands;
  logic [3:0]       op;
  logic             opMod;
  logic [2:0]       srcFmt;
  logic [2:0]       dstFmt;
  logic [1:0]       intFmt;
  logic [2:0]       rndMode;
  logic [TAGW-1:0]  tag;
  logic             outValid;
  logic             outReady;
  logic [2:0][31:0] outOperands;
  logic [3:0]       outOp;
  logic             outOpMod;
  logic [2:0]       outSrcFmt;
  logic [2:0]       outDstFmt;
  logic [1:0]       outIntFmt;
  logic [2:0]       outRndMode;
  logic [TAGW-1:0]  outTag;
  logic [1:0]       outOpgroup;
  logic             outIllegal;
  logic [CNTW-1:0]  count;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             valid;
    logic             ready;
    logic             flush;
    logic [3:0]       op;
    logic             opMod;
    logic [2:0]       src;
    logic [2:0]       dst;
    logic [1:0]       intf;
    logic [2:0]       rnd;
    logic [2:0]       frm;
    logic [TAGW-1:0]  tag;
    logic [2:0][31:0] operands;
  } stim_t;

  typedef struct {
    logic [2:0][31:0] operands;
    logic [3:0]       op;
    logic             opMod;
    logic [2:0]       src;
    logic [2:0]       dst;
    logic [1:0]       intf;
    logic [2:0]       rnd;
    logic [1:0]       grp;
    logic             ill;
    logic [TAGW-1:0]  tag;
  } expEntry_t;

  typedef struct {
    logic [3:0] op;
    logic [2:0] rnd;
    logic [2:0] frm;
    logic [2:0] src;
    logic [2:0] dst;
    logic [2:0] expRnd;
    logic [1:0] expGrp;
    logic       expIll;
  } vec_t;

  expEntry_t model[$];

  fpu_issue_queue #(.Depth(DEPTH), .TagWidth(TAGW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .frm_i          (frm),
    .in_valid_i     (inValid),
    .in_ready_o     (inReady),
    .operands_i     (operands),
    .op_i           (op),
    .op_mod_i       (opMod),
    .src_fmt_i      (srcFmt),
    .dst_fmt_i      (dstFmt),
    .int_fmt_i      (intFmt),
    .rnd_mode_i     (rndMode),
    .tag_i          (tag),
    .out_valid_o    (outValid),
    .out_ready_i    (outReady),
    .out_operands_o (outOperands),
    .out_op_o       (outOp),
    .out_op_mod_o   (outOpMod),
    .out_src_fmt_o  (outSrcFmt),
    .out_dst_fmt_o  (outDstFmt),
    .out_int_fmt_o  (outIntFmt),
    .out_rnd_mode_o (outRndMode),
    .out_tag_o      (outTag),
    .out_opgroup_o  (outOpgroup),
    .out_illegal_o  (outIllegal),
    .count_o        (count),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t idleStim();
    stim_t s;
    s.valid    = 1'b0;
    s.ready    = 1'b0;
    s.flush    = 1'b0;
    s.op       = 4'd2;
    s.opMod    = 1'b0;
    s.src      = 3'd0;
    s.dst      = 3'd0;
    s.intf     = 2'd0;
    s.rnd      = 3'd0;
    s.frm      = 3'd0;
    s.tag      = '0;
    s.operands = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001};
    return s;
  endfunction

  // Reference decode straight from the rules: DYN takes frm, modes 5..7,
  // encodings above 14 and formats above 4 are illegal, illegal stores RNE.
  function automatic expEntry_t refEnqueue(input stim_t s);
    expEntry_t  e;
    logic [2:0] resolved;
    resolved   = (s.rnd == 3'd7) ? s.frm : s.rnd;
    e.operands = s.operands;
    e.op       = s.op;
    e.opMod    = s.opMod;
    e.src      = s.src;
    e.dst      = s.dst;
    e.intf     = s.intf;
    e.tag      = s.tag;
    e.ill      = (resolved >= 3'd5) || (s.op >= 4'd15) || (s.src >= 3'd5) || (s.dst >= 3'd5);
    e.rnd      = e.ill ? 3'd0 : resolved;
    if (s.op <= 4'd3)       e.grp = 2'd0;
    else if (s.op <= 4'd5)  e.grp = 2'd1;
    else if (s.op <= 4'd9)  e.grp = 2'd2;
    else if (s.op <= 4'd14) e.grp = 2'd3;
    else                    e.grp = 2'd2;
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s);
    inValid  = s.valid;
    outReady = s.ready;
    flush    = s.flush;
    op       = s.op;
    opMod    = s.opMod;
    srcFmt   = s.src;
    dstFmt   = s.dst;
    intFmt   = s.intf;
    rndMode  = s.rnd;
    frm      = s.frm;
    tag      = s.tag;
    operands = s.operands;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predict the effect of the coming edge on the model queue.
  task automatic modelStep(input stim_t s);
    bit doPush;
    bit doPop;
    doPush = s.valid && (model.size() < DEPTH);
    doPop  = s.ready && (model.size() > 0);
    if (s.flush) begin
      model.delete();
    end else begin
      if (doPop)  void'(model.pop_front());
      if (doPush) model.push_back(refEnqueue(s));
    end
  endtask

  task automatic checkAgainstModel();
    checkOutput("rand_count", 128'(count), 128'(model.size()));
    checkOutput("rand_valid", 128'(outValid), 128'(model.size() != 0));
    checkOutput("rand_in_ready", 128'(inReady), 128'(model.size() < DEPTH));
    checkOutput("rand_busy", 128'(busy), 128'(model.size() != 0));
    if (model.size() > 0) begin
      checkOutput("rand_operands", 128'(outOperands), 128'(model[0].operands));
      checkOutput("rand_op", 128'(outOp), 128'(model[0].op));
      checkOutput("rand_op_mod", 128'(outOpMod), 128'(model[0].opMod));
      checkOutput("rand_src_fmt", 128'(outSrcFmt), 128'(model[0].src));
      checkOutput("rand_dst_fmt", 128'(outDstFmt), 128'(model[0].dst));
      checkOutput("rand_int_fmt", 128'(outIntFmt), 128'(model[0].intf));
      checkOutput("rand_rnd_mode", 128'(outRndMode), 128'(model[0].rnd));
      checkOutput("rand_opgroup", 128'(outOpgroup), 128'(model[0].grp));
      checkOutput("rand_illegal", 128'(outIllegal), 128'(model[0].ill));
      checkOutput("rand_tag", 128'(outTag), 128'(model[0].tag));
    end
  endtask

  initial begin
    stim_t s;
    vec_t  vecs[10];

    vecs[0] = '{4'd2,  3'd7, 3'd3, 3'd0, 3'd0, 3'd3, 2'd0, 1'b0};
    vecs[1] = '{4'd4,  3'd7, 3'd6, 3'd0, 3'd0, 3'd0, 2'd1, 1'b1};
    vecs[2] = '{4'd5,  3'd1, 3'd6, 3'd1, 3'd1, 3'd1, 2'd1, 1'b0};
    vecs[3] = '{4'd11, 3'd5, 3'd0, 3'd0, 3'd2, 3'd0, 2'd3, 1'b1};
    vecs[4] = '{4'd15, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 2'd2, 1'b1};
    vecs[5] = '{4'd8,  3'd4, 3'd0, 3'd5, 3'd0, 3'd0, 2'd2, 1'b1};
    vecs[6] = '{4'd3,  3'd2, 3'd7, 3'd4, 3'd4, 3'd2, 2'd0, 1'b0};
    vecs[7] = '{4'd14, 3'd7, 3'd4, 3'd3, 3'd2, 3'd4, 2'd3, 1'b0};
    vecs[8] = '{4'd0,  3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b1};
    vecs[9] = '{4'd6,  3'd7, 3'd7, 3'd0, 7'd0 /* dst */ == 0 ? 3'd0 : 3'd0, 3'd0, 2'd2, 1'b1};

    // Reset state, observed between edges while reset is held.
    rst = 1'b1;
    applyStimulus(idleStim());
    #12;
    checkOutput("reset_valid", 128'(outValid), 128'(0));
    checkOutput("reset_count", 128'(count), 128'(0));
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_in_ready", 128'(inReady), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD with DYN rounding resolved from frm=RUP, pushed on the first edge after reset.
    s = idleStim();
    s.valid = 1'b1; s.op = 4'd2; s.rnd = 3'd7; s.frm = 3'd3; s.tag = 5'd3;
    applyStimulus(s);
    tick();
    checkOutput("dyn_valid", 128'(outValid), 128'(1));
    checkOutput("dyn_rnd_mode", 128'(outRndMode), 128'(3));
    checkOutput("dyn_opgroup", 128'(outOpgroup), 128'(0));
    checkOutput("dyn_tag", 128'(outTag), 128'(3));
    s = idleStim();
    s.frm = 3'd2;
    applyStimulus(s);
    tick();
    checkOutput("frm_change_rnd", 128'(outRndMode), 128'(3));
    s.ready = 1'b1;
    applyStimulus(s);
    tick();
    checkOutput("dyn_drain_count", 128'(count), 128'(0));

    // DIV with DYN resolving to reserved mode 6.
    s = idleStim();
    s.valid = 1'b1; s.op = 4'd4; s.rnd = 3'd7; s.frm = 3'd6; s.tag = 5'd4;
    applyStimulus(s);
    tick();
    checkOutput("div_illegal", 128'(outIllegal), 128'(1));
    checkOutput("div_rnd_mode", 128'(outRndMode), 128'(0));
    checkOutput("div_opgroup", 128'(outOpgroup), 128'(1));
    s = idleStim(); s.ready = 1'b1;
    applyStimulus(s);
    tick();

    // Fill to full with the consumer stalled, then drain in order.
    s = idleStim(); s.valid = 1'b1; s.tag = 5'd1;
    applyStimulus(s);
    tick();
    s.tag = 5'd2;
    applyStimulus(s);
    tick();
    checkOutput("full_count", 128'(count), 128'(2));
    s.tag = 5'd3;
    applyStimulus(s);
    checkOutput("full_in_ready", 128'(inReady), 128'(0));
    tick();
    checkOutput("full_count_hold", 128'(count), 128'(2));
    s = idleStim(); s.ready = 1'b1;
    applyStimulus(s);
    checkOutput("drain_tag1", 128'(outTag), 128'(1));
    tick();
    checkOutput("drain_tag2", 128'(outTag), 128'(2));
    checkOutput("drain_count1", 128'(count), 128'(1));
    tick();
    checkOutput("drain_count0", 128'(count), 128'(0));

    // Simultaneous push and pop at count 1.
    s = idleStim(); s.valid = 1'b1; s.tag = 5'd7;
    applyStimulus(s);
    tick();
    s.tag = 5'd8; s.ready = 1'b1;
    applyStimulus(s);
    tick();
    checkOutput("pushpop_count", 128'(count), 128'(1));
    checkOutput("pushpop_tag", 128'(outTag), 128'(8));
    s = idleStim(); s.ready = 1'b1;
    applyStimulus(s);
    tick();

    // Flush while full with a concurrent push.
    s = idleStim(); s.valid = 1'b1; s.tag = 5'd9;
    applyStimulus(s);
    tick();
    s.tag = 5'd10;
    applyStimulus(s);
    tick();
    s.tag = 5'd11; s.flush = 1'b1; s.ready = 1'b1;
    applyStimulus(s);
    tick();
    checkOutput("flush_count", 128'(count), 128'(0));
    checkOutput("flush_valid", 128'(outValid), 128'(0));
    checkOutput("flush_in_ready", 128'(inReady), 128'(1));

    // Asynchronous reset while full, checked before the next edge.
    s = idleStim(); s.valid = 1'b1; s.tag = 5'd12;
    applyStimulus(s);
    tick();
    s.tag = 5'd13;
    applyStimulus(s);
    tick();
    applyStimulus(idleStim());
    checkOutput("async_pre_count", 128'(count), 128'(2));
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_valid", 128'(outValid), 128'(0));
    checkOutput("async_count", 128'(count), 128'(0));
    tick();
    rst = 1'b0;

    // Decode table: push one entry, check its decoded fields, pop it.
    for (int i = 0; i < 10; i++) begin
      s = idleStim();
      s.valid = 1'b1; s.op = vecs[i].op; s.rnd = vecs[i].rnd; s.frm = vecs[i].frm;
      s.src = vecs[i].src; s.dst = vecs[i].dst; s.tag = 5'(i);
      applyStimulus(s);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), 128'(outValid), 128'(1));
      checkOutput($sformatf("vec%0d_rnd", i), 128'(outRndMode), 128'(vecs[i].expRnd));
      checkOutput($sformatf("vec%0d_grp", i), 128'(outOpgroup), 128'(vecs[i].expGrp));
      checkOutput($sformatf("vec%0d_ill", i), 128'(outIllegal), 128'(vecs[i].expIll));
      s = idleStim(); s.ready = 1'b1;
      applyStimulus(s);
      tick();
      checkOutput($sformatf("vec%0d_drain", i), 128'(count), 128'(0));
    end

    // Randomized traffic against the reference queue.
    model.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      s.valid    = ($urandom_range(0, 3) != 0);
      s.ready    = ($urandom_range(0, 1) != 0);
      s.flush    = ($urandom_range(0, 19) == 0);
      s.op       = 4'($urandom_range(0, 15));
      s.opMod    = 1'($urandom_range(0, 1));
      s.src      = 3'($urandom_range(0, 5));
      s.dst      = 3'($urandom_range(0, 5));
      s.intf     = 2'($urandom_range(0, 3));
      s.rnd      = 3'($urandom_range(0, 7));
      s.frm      = 3'($urandom_range(0, 7));
      s.tag      = TAGW'($urandom);
      s.operands = {$urandom, $urandom, $urandom};
      modelStep(s);
      applyStimulus(s);
      tick();
      checkAgainstModel();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
